// File: rtl/fir_coef_pkg.sv
// Shared widths, limits and FSM state encoding for the coefficient loader.
package fir_coef_pkg;

  localparam int unsigned COEF_W    = 20;
  localparam int unsigned CADDR_W   = 11;
  localparam int unsigned CNT_W     = 12;
  localparam int unsigned MAX_COEFS = 2048;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StGap,
    StFin
  } state_t;

  // True when the requested block would run past the last coefficient slot.
  function automatic logic range_bad(input logic [CADDR_W-1:0] base,
                                     input logic [CNT_W-1:0]   count);
    logic [CNT_W:0] last_excl;
    last_excl = (CNT_W+1)'(base) + (CNT_W+1)'(count);
    return last_excl > (CNT_W+1)'(MAX_COEFS);
  endfunction

endpackage

// File: rtl/coef_byte_packer.sv
// Assembles three host bytes into one 20-bit coefficient, little-endian.
// The top byte only contributes its low nibble; a nonzero high nibble is flagged.
module coef_byte_packer
  import fir_coef_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic              word_done,
  output logic [COEF_W-1:0] word,
  output logic              nib_err
);

  logic [1:0]  cnt_q;
  logic [15:0] sr_q;

  // The third byte completes the word in the same cycle it is accepted.
  always_comb begin
    word_done = accept && (cnt_q == 2'd2);
    word      = {byte_in[3:0], sr_q};
    nib_err   = word_done && (byte_in[7:4] != 4'h0);
  end

  // Byte counter and low-byte storage; clear discards any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 2'd0;
      sr_q  <= 16'h0000;
    end else if (clear) begin
      cnt_q <= 2'd0;
    end else if (accept) begin
      unique case (cnt_q)
        2'd0: begin
          sr_q[7:0] <= byte_in;
          cnt_q     <= 2'd1;
        end
        2'd1: begin
          sr_q[15:8] <= byte_in;
          cnt_q      <= 2'd2;
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// Streams host bytes into FIR coefficient memory: packs 3 bytes per word,
// writes each word with a one-cycle CLOAD strobe, then idles GAP_CYCLES.
module fir_coef_loader
  import fir_coef_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]   word_count,
  input  logic               abort,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [COEF_W-1:0]  CIN,
  output logic [CADDR_W-1:0] CADDR,
  output logic               CLOAD,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CADDR_W-1:0] caddr_q, caddr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [3:0]         gap_q, gap_d;
  logic [COEF_W-1:0]  cin_q, cin_d;
  logic               err_q, err_d;

  logic               accept;
  logic               pk_clear;
  logic               word_done;
  logic [COEF_W-1:0]  word;
  logic               nib_err;

  // Abort wins over a byte presented in the same cycle.
  always_comb begin
    accept   = (state_q == StCollect) && byte_valid && !abort;
    pk_clear = (state_q != StCollect) || abort;
  end

  coef_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .accept    (accept),
    .byte_in   (byte_in),
    .word_done (word_done),
    .word      (word),
    .nib_err   (nib_err)
  );

  // Next-state, address, count and status logic.
  always_comb begin
    state_d = state_q;
    caddr_d = caddr_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    cin_d   = cin_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Zero-length loads finish cleanly; only overflow is an error.
          err_d = range_bad(base_addr, word_count);
          if ((word_count == '0) || range_bad(base_addr, word_count)) begin
            state_d = StFin;
          end else begin
            state_d = StCollect;
            caddr_d = base_addr;
            rem_d   = word_count;
          end
        end
      end

      StCollect: begin
        if (abort) begin
          state_d = StFin;
          err_d   = 1'b1;
        end else if (word_done) begin
          state_d = StWrite;
          cin_d   = word;
          if (nib_err) begin
            err_d = 1'b1;
          end
        end
      end

      StWrite: begin
        rem_d = rem_q - 1'b1;
        if (abort) begin
          state_d = StFin;
          err_d   = 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d = StGap;
          gap_d   = 4'd0;
        end else if (rem_q == 12'd1) begin
          state_d = StFin;
        end else begin
          state_d = StCollect;
          caddr_d = caddr_q + 1'b1;
        end
      end

      StGap: begin
        if (abort) begin
          state_d = StFin;
          err_d   = 1'b1;
        end else if (gap_q == GapLast) begin
          if (rem_q == '0) begin
            state_d = StFin;
          end else begin
            state_d = StCollect;
            caddr_d = caddr_q + 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      caddr_q <= '0;
      rem_q   <= '0;
      gap_q   <= 4'd0;
      cin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      caddr_q <= caddr_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      cin_q   <= cin_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from state so reset removes them without a clock edge.
  always_comb begin
    byte_ready = (state_q == StCollect);
    CLOAD      = (state_q == StWrite);
    busy       = (state_q != StIdle);
    done       = (state_q == StFin);
    CIN        = cin_q;
    CADDR      = caddr_q;
    err        = err_q;
  end

endmodule
